// File: rtl/mvm_host_sequencer.sv
// Host-side sequencer for the MVM accelerator. It buffers one job from a
// valid/ready input stream and bursts it into the MVM with load pulses. After
// the start pulse it collects the K results and returns them on a valid/ready
// output stream.
module mvm_host_sequencer #(
    parameter int K         = 8,
    parameter int B         = 8,
    parameter int GAP       = 2,
    parameter int OUT_DELAY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic signed [B-1:0]   s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic signed [2*B-1:0] m_data,
    output logic                  busy,
    output logic                  mvm_load_matrix,
    output logic                  mvm_load_vector,
    output logic                  mvm_start,
    output logic signed [B-1:0]   mvm_data_in,
    input  logic                  mvm_done,
    input  logic signed [2*B-1:0] mvm_data_out
);

    localparam int NW = K*K + K;
    localparam int SW = $clog2(NW);
    localparam int RW = (K > 1) ? $clog2(K) : 1;
    localparam int GW = $clog2(GAP + 1);
    localparam int DW = $clog2(OUT_DELAY + 1);

    localparam logic [SW-1:0] LAST_WORD = SW'(NW - 1);
    localparam logic [SW-1:0] LAST_MAT  = SW'(K*K - 1);
    localparam logic [RW-1:0] LAST_RES  = RW'(K - 1);
    localparam logic [GW-1:0] LAST_GAP  = GW'(GAP - 1);
    localparam logic [DW-1:0] LAST_DLY  = DW'(OUT_DELAY - 1);

    localparam logic [3:0] FILL      = 4'd0;
    localparam logic [3:0] LOAD_M    = 4'd1;
    localparam logic [3:0] BURST_M   = 4'd2;
    localparam logic [3:0] GAP_M     = 4'd3;
    localparam logic [3:0] LOAD_V    = 4'd4;
    localparam logic [3:0] BURST_V   = 4'd5;
    localparam logic [3:0] GAP_V     = 4'd6;
    localparam logic [3:0] START     = 4'd7;
    localparam logic [3:0] WAIT_DONE = 4'd8;
    localparam logic [3:0] CAPTURE   = 4'd9;
    localparam logic [3:0] DRAIN     = 4'd10;

    logic [3:0]    state;
    logic [SW-1:0] sidx;
    logic [RW-1:0] ridx;
    logic [GW-1:0] gcnt;
    logic [DW-1:0] dcnt;

    logic signed [B-1:0]   stage  [0:NW-1];
    logic signed [2*B-1:0] result [0:K-1];

    // Control path: job sequencing, burst/gap/result counters.
    // The stage index keeps running from the matrix burst into the vector burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
            sidx  <= '0;
            ridx  <= '0;
            gcnt  <= '0;
            dcnt  <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (s_valid) begin
                        if (sidx == LAST_WORD) begin
                            sidx  <= '0;
                            state <= LOAD_M;
                        end else begin
                            sidx <= sidx + 1'b1;
                        end
                    end
                end
                LOAD_M:  state <= BURST_M;
                BURST_M: begin
                    sidx <= sidx + 1'b1;
                    if (sidx == LAST_MAT) begin
                        gcnt  <= '0;
                        state <= GAP_M;
                    end
                end
                GAP_M: begin
                    if (gcnt == LAST_GAP) state <= LOAD_V;
                    else                  gcnt  <= gcnt + 1'b1;
                end
                LOAD_V:  state <= BURST_V;
                BURST_V: begin
                    if (sidx == LAST_WORD) begin
                        sidx  <= '0;
                        gcnt  <= '0;
                        state <= GAP_V;
                    end else begin
                        sidx <= sidx + 1'b1;
                    end
                end
                GAP_V: begin
                    if (gcnt == LAST_GAP) state <= START;
                    else                  gcnt  <= gcnt + 1'b1;
                end
                START:   state <= WAIT_DONE;
                WAIT_DONE: begin
                    if (mvm_done) begin
                        dcnt  <= '0;
                        ridx  <= '0;
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // Hold off OUT_DELAY-1 cycles, then take one result per cycle.
                    if (dcnt != LAST_DLY) begin
                        dcnt <= dcnt + 1'b1;
                    end else if (ridx == LAST_RES) begin
                        ridx  <= '0;
                        state <= DRAIN;
                    end else begin
                        ridx <= ridx + 1'b1;
                    end
                end
                DRAIN: begin
                    if (m_ready) begin
                        if (ridx == LAST_RES) begin
                            ridx  <= '0;
                            state <= FILL;
                        end else begin
                            ridx <= ridx + 1'b1;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    // Data path: staging buffer writes and result capture; contents need no reset
    // because every output that exposes them is gated by state.
    always_ff @(posedge clk) begin
        if (state == FILL && s_valid)
            stage[sidx] <= s_data;
        if (state == CAPTURE && dcnt == LAST_DLY)
            result[ridx] <= mvm_data_out;
    end

    // Outputs are decoded from state so each pulse is exactly one cycle wide.
    assign s_ready         = (state == FILL);
    assign busy            = (state != FILL);
    assign m_valid         = (state == DRAIN);
    assign m_data          = (state == DRAIN) ? result[ridx] : '0;
    assign mvm_load_matrix = (state == LOAD_M);
    assign mvm_load_vector = (state == LOAD_V);
    assign mvm_start       = (state == START);
    assign mvm_data_in     = (state == BURST_M || state == BURST_V) ? stage[sidx] : '0;

endmodule

// File: tb/tb_mvm_host_sequencer.sv
// Bench for mvm_host_sequencer: a behavioural MVM model answers the sequencer.
// A scoreboard holds results computed from the source job, and a table of job
// patterns drives the main runs. A reset-mid-burst sequence is written by hand.
module tb_mvm_host_sequencer;

    localparam int K = 8, B = 8, GAP = 2, OUT_DELAY = 1;
    localparam int NW = K*K + K;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic reset, s_valid, s_ready, m_valid, m_ready, busy;
    logic signed [B-1:0]   s_data;
    logic signed [2*B-1:0] m_data;
    logic lm, lv, st;
    logic signed [B-1:0]   mvm_data_in;
    logic mvm_done, model_done, force_done;
    logic signed [2*B-1:0] mvm_data_out;

    assign mvm_done = model_done | force_done;

    always #5 clk = ~clk;

    mvm_host_sequencer #(.K(K), .B(B), .GAP(GAP), .OUT_DELAY(OUT_DELAY)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy),
        .mvm_load_matrix(lm), .mvm_load_vector(lv), .mvm_start(st),
        .mvm_data_in(mvm_data_in), .mvm_done(mvm_done), .mvm_data_out(mvm_data_out)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic signed [B-1:0]   word [NW];
    logic signed [2*B-1:0] sb_q [$];
    logic signed [2*B-1:0] got  [K];

    typedef struct {
        int  mk;
        int  vk;
        bit  tog;
        bit  spur;
        bit  ends;
        logic signed [15:0] y0;
        logic signed [15:0] y7;
    } vec_t;
    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- MVM behavioural model ----------------
    logic signed [B-1:0]   mmat [K*K];
    logic signed [B-1:0]   mvec [K];
    logic signed [2*B-1:0] my   [K];
    int mmode, mcnt, mph;

    initial begin
        model_done   = 1'b0;
        mvm_data_out = 16'hDEAD;
        mmode = 0; mcnt = 0; mph = -1;
        forever begin
            tick();
            if (reset) begin
                mmode = 0; mph = -1;
                model_done = 1'b0;
                mvm_data_out = 16'hDEAD;
            end else begin
                if (lm) begin
                    mmode = 1; mcnt = 0;
                end else if (lv) begin
                    mmode = 2; mcnt = 0;
                end else if (mmode == 1) begin
                    mmat[mcnt] = mvm_data_in; mcnt++;
                    if (mcnt == K*K) mmode = 0;
                end else if (mmode == 2) begin
                    mvec[mcnt] = mvm_data_in; mcnt++;
                    if (mcnt == K) mmode = 0;
                end
                if (st) begin
                    for (int r = 0; r < K; r++) begin
                        int acc;
                        acc = 0;
                        for (int c = 0; c < K; c++)
                            acc += int'(mmat[r*K+c]) * int'(mvec[c]);
                        my[r] = acc[15:0];
                    end
                    mph = 0;
                end else if (mph >= 0) begin
                    mph++;
                end
                model_done = (mph == LAT);
                if (mph >= LAT + OUT_DELAY && mph < LAT + OUT_DELAY + K)
                    mvm_data_out = my[mph - LAT - OUT_DELAY];
                else
                    mvm_data_out = 16'hDEAD;
                if (mph >= LAT + OUT_DELAY + K) mph = -1;
            end
        end
    end

    // ---------------- job construction + scoreboard push ----------------
    task automatic build_job(input int mk, input int vk);
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                case (mk)
                    0: word[r*K+c] = (r == c) ? 8'sd1 : 8'sd0;
                    1: word[r*K+c] = -8'sd128;
                    2: word[r*K+c] = 8'sd127;
                    3: word[r*K+c] = (r == c) ? -8'sd128 : 8'sd0;
                    default: word[r*K+c] = 8'($urandom);
                endcase
        for (int c = 0; c < K; c++)
            case (vk)
                0: word[K*K+c] = 8'(c + 1);
                1: word[K*K+c] = -8'sd128;
                2: word[K*K+c] = 8'sd127;
                default: word[K*K+c] = 8'($urandom);
            endcase
        for (int r = 0; r < K; r++) begin
            int acc;
            logic signed [15:0] y;
            acc = 0;
            for (int c = 0; c < K; c++)
                acc += int'(word[r*K+c]) * int'(word[K*K+c]);
            y = acc[15:0];
            sb_q.push_back(y);
        end
    endtask

    // Feed all words with s_valid held high; spurious done mid-fill if asked.
    task automatic feed(input bit spur);
        int n, cyc;
        bit hs;
        n = 0; cyc = 0;
        s_valid = 1'b1;
        s_data  = word[0];
        while (n < NW && cyc < 500) begin
            hs = s_ready;
            force_done = spur && (n == 10);
            tick();
            cyc++;
            if (hs) begin
                n++;
                if (n < NW) s_data = word[n];
            end
        end
        s_valid = 1'b0;
        force_done = 1'b0;
        check("fill_words", n, NW);
        check("fill_cycles", cyc, NW);
        check("s_ready_after_fill", s_ready, 1'b0);
    endtask

    // Cycle-exact trace of load/burst/gap/start; returns early at abort_t.
    task automatic trace(input bit spur, input int abort_t, output bit aborted);
        logic signed [B-1:0] ed;
        aborted = 1'b0;
        for (int t = 0; t <= K*K + K + 2*GAP + 2; t++) begin
            ed = '0;
            if (t >= 1 && t <= K*K) ed = word[t-1];
            else if (t >= K*K + GAP + 2 && t <= K*K + GAP + 1 + K) ed = word[K*K + t - (K*K + GAP + 2)];
            check($sformatf("load_m_t%0d", t), lm, t == 0);
            check($sformatf("load_v_t%0d", t), lv, t == K*K + GAP + 1);
            check($sformatf("start_t%0d", t), st, t == K*K + K + 2*GAP + 2);
            check($sformatf("data_in_t%0d", t), mvm_data_in, ed);
            if (t == abort_t) begin
                aborted = 1'b1;
                return;
            end
            force_done = spur && (t == 5);
            tick();
            force_done = 1'b0;
        end
    endtask

    // Drain results with m_ready always high or toggling; compare to scoreboard.
    task automatic drain(input bit tog);
        int k, par;
        bit stalled;
        logic signed [2*B-1:0] held, exp;
        k = 0; par = 0; stalled = 1'b0; held = '0;
        for (int s = 0; s < 400 && k < K; s++) begin
            m_ready = tog ? par[0] : 1'b1;
            par++;
            if (m_valid) begin
                if (stalled) check($sformatf("stable_y%0d", k), m_data, held);
                if (m_ready) begin
                    if (sb_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL sb_empty: got result 0x%0h, expected none", m_data);
                    end else begin
                        exp = sb_q.pop_front();
                        check($sformatf("y%0d", k), m_data, exp);
                    end
                    got[k] = m_data;
                    k++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = m_data;
                end
            end
            tick();
        end
        m_ready = 1'b0;
        check("drain_count", k, K);
        check("m_valid_after_drain", m_valid, 1'b0);
        check("busy_after_drain", busy, 1'b0);
        check("s_ready_after_drain", s_ready, 1'b1);
        check("sb_left", sb_q.size(), 0);
    endtask

    task automatic run_row(input int i);
        bit ab;
        build_job(tbl[i].mk, tbl[i].vk);
        feed(tbl[i].spur);
        trace(tbl[i].spur, -1, ab);
        drain(tbl[i].tog);
        if (tbl[i].ends) begin
            check($sformatf("row%0d_y0", i), got[0], tbl[i].y0);
            check($sformatf("row%0d_y7", i), got[K-1], tbl[i].y7);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, s_ready, 1'b1);
        check({tag, "_m_valid"}, m_valid, 1'b0);
        check({tag, "_m_data"}, m_data, 16'h0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_pulses"}, {lm, lv, st}, 3'b000);
        check({tag, "_data_in"}, mvm_data_in, 8'h0);
    endtask

    initial begin
        tbl[0] = '{mk: 0, vk: 0, tog: 1'b0, spur: 1'b0, ends: 1'b1, y0: 16'sd1,     y7: 16'sd8};
        tbl[1] = '{mk: 1, vk: 1, tog: 1'b1, spur: 1'b0, ends: 1'b1, y0: 16'sd0,     y7: 16'sd0};
        tbl[2] = '{mk: 2, vk: 2, tog: 1'b1, spur: 1'b1, ends: 1'b1, y0: -16'sd2040, y7: -16'sd2040};
        tbl[3] = '{mk: 3, vk: 1, tog: 1'b0, spur: 1'b1, ends: 1'b1, y0: 16'sd16384, y7: 16'sd16384};
        tbl[4] = '{mk: 9, vk: 9, tog: 1'b1, spur: 1'b1, ends: 1'b0, y0: 16'sd0,     y7: 16'sd0};

        reset = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; force_done = 1'b0;
        tick(); tick(); tick();
        check_reset_outputs("rst_init");
        reset = 1'b0;
        tick();
        check_reset_outputs("post_rst");

        for (int i = 0; i < 5; i++) run_row(i);

        // Reset while word 30 of the matrix burst is on mvm_data_in.
        begin
            bit ab;
            build_job(0, 0);
            feed(1'b0);
            trace(1'b0, 31, ab);
            check("abort_reached", ab, 1'b1);
            reset = 1'b1;
            tick();
            check_reset_outputs("rst_mid");
            tick();
            check_reset_outputs("rst_hold");
            reset = 1'b0;
            sb_q.delete();
            tick();
            check_reset_outputs("rst_after");
            run_row(0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
